// File: rtl/pipe_pkg.sv
// Types shared by every pipeline-stage register.
// Occupancy of a stage: no entry, MAIN only, or MAIN plus SKID.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } stage_state_e;

endpackage

// File: rtl/pipe_reg_entry.sv
// One storage slot of a stage register: a ctrl+data word with load enable.
// Clear has priority over load so a kill never lets new contents through.
module pipe_reg_entry #(
  parameter int W = 48
) (
  input  logic         clock,
  input  logic         clear_i,
  input  logic         load_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] entryQ;

  always_ff @(posedge clock) begin
    if (clear_i) begin
      entryQ <= '0;
    end else if (load_i) begin
      entryQ <= d_i;
    end
  end

  assign q_o = entryQ;

endmodule

// File: rtl/pipe_stage_reg.sv
// Two-entry (MAIN + SKID) pipeline stage register with stall, flush,
// bubble zeroing and a saturating stall-cycle counter.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              nreset,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cycles
);

  localparam int EntryW = CTRL_W + DATA_W;

  stage_state_e      stateQ, stateD;
  logic [EntryW-1:0] mainQ, skidQ, mainD;
  logic              mainLoad, skidLoad, entryClear;
  logic              accept, issue;
  logic [CNT_W-1:0]  stallCntQ;

  // Gating on nreset keeps both handshakes quiet while reset is held,
  // even before the first reset edge has emptied the stage.
  assign in_ready  = nreset & ~stall & ~flush & (stateQ != TWO);
  assign out_valid = nreset & ~stall & (stateQ != EMPTY);
  assign accept    = in_valid & in_ready;
  assign issue     = out_valid & out_ready;
  assign entryClear = ~nreset | flush;

  always_comb begin
    stateD   = stateQ;
    mainD    = {in_ctrl, in_data};
    mainLoad = 1'b0;
    skidLoad = 1'b0;
    case (stateQ)
      EMPTY: begin
        if (accept) begin
          stateD   = ONE;
          mainLoad = 1'b1;
        end
      end
      ONE: begin
        if (accept && !issue) begin
          stateD   = TWO;
          skidLoad = 1'b1;
        end else if (issue && !accept) begin
          stateD = EMPTY;
        end else if (accept && issue) begin
          mainLoad = 1'b1;
        end
      end
      TWO: begin
        if (issue) begin
          stateD   = ONE;
          mainD    = skidQ;
          mainLoad = 1'b1;
        end
      end
      default: stateD = EMPTY;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!nreset || flush) begin
      stateQ <= EMPTY;
    end else begin
      stateQ <= stateD;
    end
  end

  pipe_reg_entry #(.W(EntryW)) mainEntry (
    .clock   (clock),
    .clear_i (entryClear),
    .load_i  (mainLoad),
    .d_i     (mainD),
    .q_o     (mainQ)
  );

  pipe_reg_entry #(.W(EntryW)) skidEntry (
    .clock   (clock),
    .clear_i (entryClear),
    .load_i  (skidLoad),
    .d_i     ({in_ctrl, in_data}),
    .q_o     (skidQ)
  );

  // Counts only stalls that actually freeze held data; flush leaves it alone.
  always_ff @(posedge clock) begin
    if (!nreset) begin
      stallCntQ <= '0;
    end else if (stall && (stateQ != EMPTY) && (stallCntQ != '1)) begin
      stallCntQ <= stallCntQ + CNT_W'(1);
    end
  end

  assign stall_cycles = stallCntQ;
  assign {out_ctrl, out_data} = out_valid ? mainQ : '0;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench: directed vectors push expected entries, an occupancy
// model predicts handshakes, and a monitor compares every issued entry.
module tb_pipe_stage_reg;

  typedef struct packed {
    logic [15:0] c;
    logic [31:0] d;
  } entry_t;

  logic        clock = 1'b0;
  logic        nreset = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_ctrl = '0;
  logic [31:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_ctrl;
  logic [31:0] out_data;
  logic [3:0]  stall_cycles;

  entry_t sbq[$];
  int checks = 0;
  int errors = 0;
  int popCount = 0;
  int mCnt = 0;
  int expStall = 0;

  pipe_stage_reg #(.DATA_W(32), .CTRL_W(16), .CNT_W(4)) dut (
    .clock        (clock),
    .nreset       (nreset),
    .stall        (stall),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_ctrl      (in_ctrl),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_ctrl     (out_ctrl),
    .out_data     (out_data),
    .stall_cycles (stall_cycles)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle of stimulus, driven just after the rising edge.
  task automatic applyStimulus(input logic v, input logic [15:0] c, input logic [31:0] d,
                               input logic st, input logic fl, input logic ordy);
    @(posedge clock);
    #1;
    nreset    = 1'b1;
    in_valid  = v;
    in_ctrl   = c;
    in_data   = d;
    stall     = st;
    flush     = fl;
    out_ready = ordy;
  endtask

  task automatic applyReset(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
      nreset   = 1'b0;
      in_valid = 1'b1;
      in_data  = 32'hDEAD0000 + i;
      stall    = 1'b0;
      flush    = 1'b0;
    end
  endtask

  // Monitor: pops the scoreboard on each issue and checks bubble zeroing.
  always @(negedge clock) begin
    entry_t e;
    #1;
    if (nreset && out_valid && out_ready) begin
      if (sbq.size() == 0) begin
        checkOutput("spurious_issue", {16'h0, out_ctrl, out_data}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        e = sbq.pop_front();
        popCount++;
        checkOutput("issue_entry", {16'h0, out_ctrl, out_data}, {16'h0, e.c, e.d});
      end
    end
    if (!out_valid) begin
      checkOutput("bubble_zero", {16'h0, out_ctrl, out_data}, 64'h0);
    end
  end

  // Occupancy model: predicts handshakes and the stall counter.
  always @(negedge clock) begin
    logic expIr, expOv, acc, iss;
    #2;
    if (!nreset) begin
      checkOutput("reset_in_ready", {63'h0, in_ready}, 64'h0);
      checkOutput("reset_out_valid", {63'h0, out_valid}, 64'h0);
      mCnt = 0;
      expStall = 0;
      sbq.delete();
    end else begin
      expIr = !stall && !flush && (mCnt != 2);
      expOv = !stall && (mCnt != 0);
      checkOutput("in_ready", {63'h0, in_ready}, {63'h0, expIr});
      checkOutput("out_valid", {63'h0, out_valid}, {63'h0, expOv});
      checkOutput("stall_cycles", {60'h0, stall_cycles}, 64'(expStall));
      acc = in_valid && expIr;
      iss = expOv && out_ready;
      if (stall && mCnt != 0 && expStall != 15) expStall++;
      if (flush) begin
        mCnt = 0;
        sbq.delete();
      end else begin
        if (acc) sbq.push_back({in_ctrl, in_data});
        mCnt = mCnt + int'(acc) - int'(iss);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int basePop;
    applyReset(2);

    // Single entry: one-cycle latency
    applyStimulus(1, 16'h0003, 32'h12345678, 0, 0, 1);
    applyStimulus(0, 16'h0, 32'h0, 0, 0, 1);
    applyStimulus(0, 16'h0, 32'h0, 0, 0, 1);
    checkOutput("latency_pop", 64'(popCount), 64'd1);

    // Fill both slots, hold C, then drain A,B,C back to back
    applyStimulus(1, 16'h0001, 32'h11, 0, 0, 0);
    applyStimulus(1, 16'h0002, 32'h22, 0, 0, 0);
    applyStimulus(1, 16'h0004, 32'h33, 0, 0, 0);
    applyStimulus(1, 16'h0004, 32'h33, 0, 0, 1);
    applyStimulus(1, 16'h0004, 32'h33, 0, 0, 1);
    applyStimulus(0, 16'h0, 32'h0, 0, 0, 1);
    applyStimulus(0, 16'h0, 32'h0, 0, 0, 1);
    checkOutput("abc_pop", 64'(popCount), 64'd4);

    // Hold 0xAA through five stall cycles
    applyStimulus(1, 16'h00AA, 32'hAA, 0, 0, 0);
    for (int i = 0; i < 5; i++) applyStimulus(1, 16'h00BB, 32'hBB, 1, 0, 1);
    applyStimulus(0, 16'h0, 32'h0, 0, 0, 1);
    checkOutput("stall_count5", {60'h0, stall_cycles}, 64'd5);
    applyStimulus(0, 16'h0, 32'h0, 0, 0, 1);
    checkOutput("stall_release_pop", 64'(popCount), 64'd5);

    // Flush with stall and in_valid while full
    applyStimulus(1, 16'h0010, 32'h1, 0, 0, 0);
    applyStimulus(1, 16'h0020, 32'h2, 0, 0, 0);
    applyStimulus(1, 16'h0030, 32'h3, 1, 1, 0);
    basePop = popCount;
    applyStimulus(0, 16'h0, 32'h0, 0, 0, 1);
    applyStimulus(0, 16'h0, 32'h0, 0, 0, 1);
    applyStimulus(0, 16'h0, 32'h0, 0, 0, 1);
    checkOutput("flush_no_emerge", 64'(popCount), 64'(basePop));

    // Counter saturation with data held
    applyStimulus(1, 16'h0050, 32'h55, 0, 0, 0);
    for (int i = 0; i < 20; i++) applyStimulus(0, 16'h0, 32'h0, 1, 0, 0);
    applyStimulus(0, 16'h0, 32'h0, 0, 0, 1);
    checkOutput("stall_saturate", {60'h0, stall_cycles}, 64'd15);
    applyStimulus(0, 16'h0, 32'h0, 0, 0, 1);

    // Reset mid-transfer discards held entries
    applyStimulus(1, 16'h0060, 32'h66, 0, 0, 0);
    applyStimulus(1, 16'h0070, 32'h77, 0, 0, 0);
    basePop = popCount;
    applyReset(1);
    applyStimulus(1, 16'h0080, 32'h88, 0, 0, 1);
    applyStimulus(0, 16'h0, 32'h0, 0, 0, 1);
    applyStimulus(0, 16'h0, 32'h0, 0, 0, 1);
    checkOutput("post_reset_pop", 64'(popCount), 64'(basePop + 1));
    checkOutput("post_reset_stall_cnt", {60'h0, stall_cycles}, 64'd0);

    // Mixed traffic against the scoreboard
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 16'($urandom), $urandom,
                    ($urandom_range(0, 7) == 0), ($urandom_range(0, 31) == 0),
                    1'($urandom_range(0, 1)));
    end

    for (int i = 0; i < 4; i++) applyStimulus(0, 16'h0, 32'h0, 0, 0, 1);
    checkOutput("drain_empty", 64'(sbq.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
